// File: rtl/tia_hctr_pkg.sv
// Shared step indices, LFSR encodings and the polynomial step function for the
// TIA horizontal counter. Encodings are derived from the polynomial at elaboration.
package tia_hctr_pkg;

  localparam int STEPS_PER_LINE = 57;

  localparam int STEP_SHB      = 0;
  localparam int STEP_SHS      = 4;
  localparam int STEP_RHS      = 8;
  localparam int STEP_RCB      = 12;
  localparam int STEP_RHB      = 16;
  localparam int STEP_RHB_LATE = 18;
  localparam int STEP_CNT      = 36;
  localparam int STEP_WRAP     = 56;

  localparam logic [5:0] LFSR_ZERO = 6'b000000;
  localparam logic [5:0] LFSR_LOCK = 6'b111111;

  function automatic logic [5:0] lfsr_next(input logic [5:0] q);
    return {q[4:0], ~(q[5] ^ q[4])};
  endfunction

  // Walks the polynomial from step 0 so no encoding is ever typed by hand.
  function automatic logic [5:0] lfsr_at(input int step);
    logic [5:0] q;
    q = LFSR_ZERO;
    for (int i = 0; i < step; i++) q = lfsr_next(q);
    return q;
  endfunction

  localparam logic [5:0] HC_SHB      = lfsr_at(STEP_SHB);
  localparam logic [5:0] HC_SHS      = lfsr_at(STEP_SHS);
  localparam logic [5:0] HC_RHS      = lfsr_at(STEP_RHS);
  localparam logic [5:0] HC_RCB      = lfsr_at(STEP_RCB);
  localparam logic [5:0] HC_RHB      = lfsr_at(STEP_RHB);
  localparam logic [5:0] HC_RHB_LATE = lfsr_at(STEP_RHB_LATE);
  localparam logic [5:0] HC_CNT      = lfsr_at(STEP_CNT);
  localparam logic [5:0] HC_WRAP     = lfsr_at(STEP_WRAP);

endpackage

// File: rtl/tia_hctr_lfsr6.sv
// 6-bit XNOR polynomial counter: shifts on adv, returns to step 0 after the
// last step of the line, escapes the all-ones lockup, and loads step 0 on load0.
module tia_lfsr6
  import tia_hctr_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adv,
  input  logic       load0,
  output logic [5:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= LFSR_ZERO;
    end else if (load0) begin
      q <= LFSR_ZERO;
    end else if (adv) begin
      if (q == HC_WRAP || q == LFSR_LOCK) q <= LFSR_ZERO;
      else                                q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/tia_hctr.sv
// TIA horizontal timing: colour clock / 4 phase enables, polynomial line
// counter and single-cycle step decodes for the DL latches.
module tia_hctr
  import tia_hctr_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rsync,
  input  logic       hmove_late,
  output logic       phi1,
  output logic       phi2,
  output logic       shb,
  output logic       shs,
  output logic       rhs,
  output logic       rcb,
  output logic       rhb,
  output logic       cnt,
  output logic       wrap,
  output logic [5:0] hcount
);

  logic [1:0] ph;
  logic [5:0] hc_rhb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ph <= 2'd0;
    else if (rsync) ph <= 2'd0;
    else            ph <= ph + 2'd1;
  end

  // Step advances on the last phase, so each step spans one full phi1..phi2 cycle.
  tia_lfsr6 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (ph == 2'd3),
    .load0   (rsync),
    .q       (hcount)
  );

  assign phi1   = (ph == 2'd0);
  assign phi2   = (ph == 2'd2);
  assign hc_rhb = hmove_late ? HC_RHB_LATE : HC_RHB;

  assign shb  = phi2 && (hcount == HC_SHB);
  assign shs  = phi2 && (hcount == HC_SHS);
  assign rhs  = phi2 && (hcount == HC_RHS);
  assign rcb  = phi2 && (hcount == HC_RCB);
  assign rhb  = phi2 && (hcount == hc_rhb);
  assign cnt  = phi2 && (hcount == HC_CNT);
  assign wrap = phi2 && (hcount == HC_WRAP);

endmodule

// File: tb/tb_tia_hctr.sv
// Bench for tia_hctr: directed line timelines plus randomized rsync/hmove/reset
// traffic checked cycle by cycle against a line-position reference model.
module tb_tia_hctr;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rsync = 1'b0;
  logic       hmove_late = 1'b0;
  logic       phi1, phi2, shb, shs, rhs, rcb, rhb, cnt, wrap;
  logic [5:0] hcount;

  tia_hctr dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rsync      (rsync),
    .hmove_late (hmove_late),
    .phi1       (phi1),
    .phi2       (phi2),
    .shb        (shb),
    .shs        (shs),
    .rhs        (rhs),
    .rcb        (rcb),
    .rhb        (rhb),
    .cnt        (cnt),
    .wrap       (wrap),
    .hcount     (hcount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pos      = 0;
  int n_lock   = 0;
  logic [5:0] enc [57];
  int q_shb[$], q_shs[$], q_rhs[$], q_rcb[$], q_rhb[$], q_cnt[$], q_wrap[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Model: the line is 228 colour clocks; position p gives phase p%4 and step p/4.
  function automatic logic [8:0] exp_outs(input int p, input logic hm);
    int  ph, st;
    logic p2;
    ph = p % 4;
    st = p / 4;
    p2 = (ph == 2);
    return {ph == 0, p2, p2 && st == 0, p2 && st == 4, p2 && st == 8, p2 && st == 12,
            p2 && st == (hm ? 18 : 16), p2 && st == 36, p2 && st == 56};
  endfunction

  function automatic int first_after(input int q[$], input int t);
    foreach (q[i]) if (q[i] > t) return q[i];
    return -1;
  endfunction

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  task automatic clear_events();
    q_shb.delete(); q_shs.delete(); q_rhs.delete(); q_rcb.delete();
    q_rhb.delete(); q_cnt.delete(); q_wrap.delete();
  endtask

  // Called at negedge: drive inputs, check the cycle, clock it, advance the model.
  task automatic tick(input logic rs, input logic hm);
    rsync = rs;
    hmove_late = hm;
    #1;
    chk("outs", {23'd0, phi1, phi2, shb, shs, rhs, rcb, rhb, cnt, wrap}, {23'd0, exp_outs(pos, hm)});
    chk("hcount", {26'd0, hcount}, {26'd0, enc[pos / 4]});
    if (hcount == 6'h3f) n_lock++;
    if (shb)  q_shb.push_back(cyc);
    if (shs)  q_shs.push_back(cyc);
    if (rhs)  q_rhs.push_back(cyc);
    if (rcb)  q_rcb.push_back(cyc);
    if (rhb)  q_rhb.push_back(cyc);
    if (cnt)  q_cnt.push_back(cyc);
    if (wrap) q_wrap.push_back(cyc);
    @(posedge clk);
    pos = rs ? 0 : (pos + 1) % 228;
    cyc++;
    @(negedge clk);
  endtask

  // Called at negedge: asserts reset between edges, checks the async effect, releases.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    rsync = 1'b0;
    #1;
    chk("rst_outs", {23'd0, phi1, phi2, shb, shs, rhs, rcb, rhb, cnt, wrap}, 32'h100);
    chk("rst_hcount", {26'd0, hcount}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pos = 0;
    cyc = 0;
    clear_events();
  endtask

  task automatic run(input int n, input logic hm);
    for (int i = 0; i < n; i++) tick(1'b0, hm);
  endtask

  initial begin
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < 57; i++) begin
      enc[i] = s;
      s = {s[4:0], ~(s[5] ^ s[4])};
    end

    @(negedge clk);
    async_reset();

    // Normal line timeline from reset
    run(460, 1'b0);
    chk("l1_shb",  first_after(q_shb, -1), 2);
    chk("l1_shs",  first_after(q_shs, -1), 18);
    chk("l1_rhs",  first_after(q_rhs, -1), 34);
    chk("l1_rcb",  first_after(q_rcb, -1), 50);
    chk("l1_rhb",  first_after(q_rhb, -1), 66);
    chk("l1_cnt",  first_after(q_cnt, -1), 146);
    chk("l1_wrap", first_after(q_wrap, -1), 226);
    chk("l2_shb",  first_after(q_shb, 2), 230);
    chk("l3_shb",  first_after(q_shb, 230), 458);

    // HMOVE late blank end for a whole line
    async_reset();
    run(228, 1'b1);
    chk("late_rhb_n", count_in(q_rhb, 0, 227), 1);
    chk("late_rhb",   first_after(q_rhb, -1), 74);
    chk("late_shs",   first_after(q_shs, -1), 18);
    chk("late_cnt",   first_after(q_cnt, -1), 146);

    // RSYNC mid-line
    async_reset();
    run(100, 1'b0);
    tick(1'b1, 1'b0);
    run(40, 1'b0);
    chk("rs_shb", first_after(q_shb, 100), 103);
    chk("rs_shs", first_after(q_shs, 100), 119);

    // RSYNC on the step-56 advance edge
    async_reset();
    run(227, 1'b0);
    tick(1'b1, 1'b0);
    run(30, 1'b0);
    chk("rswrap_shb_n", count_in(q_shb, 220, 256), 1);
    chk("rswrap_shb",   first_after(q_shb, 200), 230);

    // Reset pulsed mid-step, timeline reproduced afterwards
    async_reset();
    run(77, 1'b0);
    async_reset();
    run(240, 1'b0);
    chk("mr_shb",  first_after(q_shb, -1), 2);
    chk("mr_rhb",  first_after(q_rhb, -1), 66);
    chk("mr_wrap", first_after(q_wrap, -1), 226);
    chk("mr_shb2", first_after(q_shb, 2), 230);

    // Random rsync / hmove / reset traffic
    begin
      logic hm;
      hm = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) hm = ~hm;
        if ($urandom_range(0, 799) == 0) async_reset();
        else tick($urandom_range(0, 199) == 0, hm);
      end
    end

    chk("no_lockup", n_lock, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
